// File: rtl/data_memory_unit.sv
// data_memory_unit
// Single-clock data memory for the CPU load/store path.
// Byte/half/word requests over a valid/ready handshake, byte-lane store
// masking, sign/zero-extended loads, and error flagging for misaligned,
// out-of-range or reserved-size accesses. Each accepted request returns a
// one-cycle response on the following edge. An optional post-reset clear
// zeroes the whole array before the first request is accepted.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   request handshake
//   req_we                1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned          load zero-extends when 1
//   req_addr              byte address
//   req_wdata             right-aligned store data
//   rsp_valid             one-cycle response pulse
//   rsp_rdata             extended load data (0 for stores/errors)
//   rsp_err               access rejected
//   busy                  clear sequence in progress
//
// state   | meaning
// S_CLEAR | zeroing word clr_idx each edge; requests not accepted
// S_IDLE  | accepting one request per cycle
module data_memory_unit #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DEPTH_WORDS    = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = $clog2(DEPTH_WORDS);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  state_t             state, state_nxt;
  logic [MEM_AW-1:0]  clr_idx;
  logic               clr_last;
  logic [31:0]        mem [DEPTH_WORDS];

  logic [IDX_W-1:0]   word_idx;
  logic [MEM_AW-1:0]  mem_idx;
  logic [1:0]         lane;
  logic               in_range, err, accept, wr_en;
  logic [3:0]         byte_en;
  logic [31:0]        wdata_rep, rd_word, load_data;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;

  assign clr_last = (clr_idx == MEM_AW'(DEPTH_WORDS - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESET_STATE;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR)
        clr_idx <= clr_last ? '0 : clr_idx + MEM_AW'(1);
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && clr_last)
      state_nxt = S_IDLE;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = 1'b0;
    req_ready = 1'b0;
    if (state == S_CLEAR) busy = 1'b1;
    else                  req_ready = 1'b1;
  end

  // ---------------- address decode and error check ----------------
  assign word_idx = req_addr[ADDR_WIDTH-1:2];
  assign lane     = req_addr[1:0];
  assign mem_idx  = word_idx[MEM_AW-1:0];
  assign in_range = ({1'b0, word_idx} < (IDX_W + 1)'(DEPTH_WORDS));

  always_comb begin
    err = !in_range;
    case (req_size)
      2'b01:   if (lane[0])       err = 1'b1;
      2'b10:   if (lane != 2'b00) err = 1'b1;
      2'b11:   err = 1'b1;
      default: ;
    endcase
  end

  assign accept = req_valid && req_ready;
  assign wr_en  = accept && req_we && !err;

  // Store data is replicated across lanes so the byte mask alone picks it.
  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        byte_en[lane] = 1'b1;
        wdata_rep     = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: ;
    endcase
  end

  // ---------------- array ----------------
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (byte_en[i]) mem[mem_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
    end
  end

  // ---------------- load extraction ----------------
  assign rd_word = mem[mem_idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    case (req_size)
      2'b00:   load_data = {{24{!req_unsigned && rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{16{!req_unsigned && rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  // ---------------- response ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && err;
      rsp_rdata <= (accept && !req_we && !err) ? load_data : '0;
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
module tb_data_memory_unit;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          busy;

  always #5 clk = ~clk;

  data_memory_unit #(
    .ADDR_WIDTH(AW),
    .DEPTH_WORDS(DW),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .busy(busy)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] mm [0:4*DW-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4*DW; i++) mm[i] = 8'h00;
  endfunction

  // Byte-addressed reference memory; loads assemble little-endian bytes.
  function automatic rsp_t model(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [AW-1:0] addr, input logic [31:0] wdata);
    rsp_t r;
    int   a;
    logic [7:0]  b;
    logic [15:0] h;
    a = int'(addr);
    r.err = (size == 2'b11) || (size == 2'b01 && a % 2 != 0) ||
            (size == 2'b10 && a % 4 != 0) || (a / 4 >= DW);
    r.rdata = 32'h0;
    if (r.err) return r;
    if (we) begin
      if (size == 2'b00) mm[a] = wdata[7:0];
      else if (size == 2'b01) begin
        mm[a] = wdata[7:0]; mm[a+1] = wdata[15:8];
      end else begin
        mm[a] = wdata[7:0]; mm[a+1] = wdata[15:8];
        mm[a+2] = wdata[23:16]; mm[a+3] = wdata[31:24];
      end
    end else begin
      if (size == 2'b00) begin
        b = mm[a];
        r.rdata = uns ? {24'h0, b} : {{24{b[7]}}, b};
      end else if (size == 2'b01) begin
        h = {mm[a+1], mm[a]};
        r.rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
      end else begin
        r.rdata = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
      end
    end
    return r;
  endfunction

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rsp: got err=%b rdata=%h, expected no response", rsp_err, rsp_rdata);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        if ({rsp_err, rsp_rdata} !== e) begin
          n_bad++;
          $display("FAIL rsp: got err=%b rdata=%h, expected err=%b rdata=%h",
                   rsp_err, rsp_rdata, e.err, e.rdata);
        end
      end
    end
  end

  // Called at #1 after an edge; drives for one edge, leaves time at #1 after it.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [AW-1:0] addr, input logic [31:0] wdata);
    int n = 0;
    while (req_ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (req_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: got req_ready=%b, expected 1", req_ready);
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    exp_q.push_back(model(we, size, uns, addr, wdata));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_clear();
    int n;
    bit busy_ok;
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h1);
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; busy_ok = 1'b1;
    while (req_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
      if (req_ready !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
    end
    check("clear_edges", n, 16);
    check("busy_during_clear", {31'h0, busy_ok}, 32'h1);
    check("busy_after_clear", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int n;
    logic [1:0] sz;
    logic [AW-1:0] ad;
    int r;

    #2;
    check("por_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("por_rsp_rdata", rsp_rdata, 32'h0);
    check("por_busy", {31'h0, busy}, 32'h1);
    reset_clear();
    @(posedge clk); #1;

    // directed scenario from the plan
    issue(1'b0, 2'b10, 1'b0, 16'h003C, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 16'h0011, 32'h00000012);
    issue(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 16'h0012, 32'h0000A5A5);
    issue(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 16'h0013, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 16'h0013, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 16'h0010, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 16'h0012, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 16'h0012, 32'h11111111);
    issue(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 16'h0011, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 16'h0010, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 16'h0010, 32'h55555555);
    issue(1'b1, 2'b10, 1'b0, 16'h0040, 32'h77777777);
    issue(1'b0, 2'b10, 1'b0, 16'h0040, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0);
    drain();

    // randomized traffic, including idle gaps and out-of-range addresses
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      ad = ($urandom_range(0, 15) == 0) ? AW'($urandom) : AW'($urandom_range(0, 4*DW + 7));
      issue(1'(($urandom_range(0, 1))), sz, 1'(($urandom_range(0, 1))), ad, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();

    // reset in the middle of a clear restarts it from word 0
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midclear_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("midclear_restart_edges", n, 16);

    // every word must read back zero after the clear
    for (int w = 0; w < DW; w++) issue(1'b0, 2'b10, 1'b0, AW'(4*w), 32'h0);
    issue(1'b1, 2'b10, 1'b0, 16'h0020, 32'hCAFEF00D);
    issue(1'b0, 2'b01, 1'b0, 16'h0022, 32'h0);
    drain();

    // reset during a response cycle drops it asynchronously
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 16'h0020; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rsp_before_reset", {31'h0, rsp_valid}, 32'h1);
    check("rsp_rdata_before_reset", rsp_rdata, 32'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    check("rsp_dropped_async", {31'h0, rsp_valid}, 32'h0);
    check("rsp_rdata_dropped_async", rsp_rdata, 32'h0);
    reset_clear();
    issue(1'b0, 2'b10, 1'b0, 16'h0020, 32'h0);
    drain();

    check("outstanding_rsps", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
